ad7782_reader: RTL and testbench

- Slave-mode serial front end for the AD7782 24-bit sigma-delta ADC.
- Sits between the ADC pins (ADCdin, ADCcs, ADCsclk, ADCmode, ADCrng, ADCsel) and the command master inside the connector.
- On a start request it selects channel and range, waits for DOUT/RDY, shifts in one 24-bit conversion, and holds it for the master under a valid/ack handshake.

---
 rtl/ad7782_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/ad7782_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_ad7782_reader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7782_pkg.sv
// Shared types and constants for the AD7782 slave-mode reader.
// The optional RDY timeout is enabled with the AD7782_TIMEOUT_EN macro.
package ad7782_pkg;

  localparam int AD7782_DATA_W = 24;

  // ADCrng encoding
  localparam logic RNG_2V56  = 1'b0;
  localparam logic RNG_160MV = 1'b1;

  // ADCsel encoding
  localparam logic CH_AIN1 = 1'b0;
  localparam logic CH_AIN2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_RDY,
    SHIFT,
    DONE
  } state_e;

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset and a
// configurable reset value, for asynchronous inputs such as ADCdin, rxd or eepromMISO.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ad7782_reader.sv
// AD7782 slave-mode reader: selects channel/range, waits for DOUT/RDY, clocks in
// one 24-bit word and holds it under a valid/ack handshake. Macro: AD7782_TIMEOUT_EN.
//
// Handshake: data_valid rises with data in the same cycle and stays high with
// data stable until data_ack is sampled high; the next edge drops data_valid
// and returns to IDLE. data_ack while data_valid is low has no effect.
module ad7782_reader
  import ad7782_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int SETUP_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     channel,
  input  logic                     range,
  input  logic                     ADCdin,
  output logic                     ADCcs,
  output logic                     ADCsclk,
  output logic                     ADCmode,
  output logic                     ADCrng,
  output logic                     ADCsel,
  output logic [AD7782_DATA_W-1:0] data,
  output logic                     data_valid,
  input  logic                     data_ack,
  output logic                     busy,
  output logic                     timeout,
  output state_e                   dbg_state
);

  localparam int DIV_W = ctr_width(2 * CLK_DIV);
  localparam int SET_W = ctr_width(SETUP_CYCLES);
  localparam int BIT_W = ctr_width(AD7782_DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(AD7782_DATA_W - 1);

  if (CLK_DIV < 3) begin : g_bad_clk_div
    $error("ad7782_reader: CLK_DIV must be >= 3");
  end
  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("ad7782_reader: SETUP_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ad7782_reader: TIMEOUT_CYCLES must be >= 1");
  end

  logic din_s;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_din_sync (
    .clk  (clk),
    .rst_n(rst),
    .d    (ADCdin),
    .q    (din_s)
  );

  state_e                   state_q, state_d;
  logic                     cs_q, cs_d;
  logic                     sclk_q, sclk_d;
  logic                     sel_q, sel_d;
  logic                     rng_q, rng_d;
  logic [AD7782_DATA_W-1:0] data_q, data_d;
  logic [AD7782_DATA_W-1:0] shift_q, shift_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [DIV_W-1:0]         div_inc;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [SET_W-1:0]         set_q, set_d;

`ifdef AD7782_TIMEOUT_EN
  localparam int TMO_W = ctr_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  assign div_inc = div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    sel_d   = sel_q;
    rng_d   = rng_q;
    data_d  = data_q;
    shift_d = shift_q;
    valid_d = valid_q;
    div_d   = div_q;
    bit_d   = bit_q;
    set_d   = set_q;
`ifdef AD7782_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          sel_d   = channel;
          rng_d   = range;
          set_d   = '0;
          shift_d = '0;
        end
      end

      SETUP: begin
        if (set_q == SET_LAST) begin
          state_d = WAIT_RDY;
          set_d   = '0;
`ifdef AD7782_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          set_d = set_q + 1'b1;
        end
      end

      WAIT_RDY: begin
        // The first low phase starts on the same edge that leaves WAIT_RDY.
        if (!din_s) begin
          state_d = SHIFT;
          bit_d   = BIT_MSB;
          div_d   = '0;
          sclk_d  = 1'b0;
        end
`ifdef AD7782_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          cs_d      = 1'b1;
          timeout_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          // Last cycle of the high phase: the ADC output has settled for a full bit.
          shift_d[bit_q] = din_s;
          div_d          = '0;
          if (bit_q == '0) begin
            state_d = DONE;
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
            data_d  = shift_d;
            valid_d = 1'b1;
          end else begin
            bit_d  = bit_q - 1'b1;
            sclk_d = 1'b0;
          end
        end else begin
          div_d  = div_inc;
          sclk_d = (div_inc >= DIV_HALF);
        end
      end

      DONE: begin
        if (data_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      sel_q   <= CH_AIN1;
      rng_q   <= RNG_2V56;
      data_q  <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      set_q   <= '0;
`ifdef AD7782_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sel_q   <= sel_d;
      rng_q   <= rng_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      set_q   <= set_d;
`ifdef AD7782_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign ADCcs      = cs_q;
  assign ADCsclk    = sclk_q;
  assign ADCmode    = 1'b1;
  assign ADCrng     = rng_q;
  assign ADCsel     = sel_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

`ifdef AD7782_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ad7782_reader.sv
// Directed bench for ad7782_reader with a behavioural AD7782 DOUT/RDY model.
// Build with +define+AD7782_TIMEOUT_EN to exercise the RDY timeout.
`timescale 1ns/1ps
module tb_ad7782_reader;
  import ad7782_pkg::*;

  localparam int CLK_DIV        = 4;
  localparam int SETUP_CYCLES   = 16;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int RDY_DELAY      = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        channel = 1'b0;
  logic        range = 1'b0;
  logic        ADCdin = 1'b1;
  logic        data_ack = 1'b0;
  logic        ADCcs, ADCsclk, ADCmode, ADCrng, ADCsel;
  logic [23:0] data;
  logic        data_valid, busy, timeout;
  state_e      dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];

  ad7782_reader #(
    .CLK_DIV       (CLK_DIV),
    .SETUP_CYCLES  (SETUP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .channel   (channel),
    .range     (range),
    .ADCdin    (ADCdin),
    .ADCcs     (ADCcs),
    .ADCsclk   (ADCsclk),
    .ADCmode   (ADCmode),
    .ADCrng    (ADCrng),
    .ADCsel    (ADCsel),
    .data      (data),
    .data_valid(data_valid),
    .data_ack  (data_ack),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter / ADCsclk monitor ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  int   fall_cnt = 0;
  int   period_bad = 0;
  int   last_fall = 0;
  logic mon_prev = 1'b1;

  // Gaps of 64+ cycles separate conversions, so only shorter gaps are checked.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_prev && !ADCsclk) begin
      if (fall_cnt > 0 && (cyc - last_fall) != 2 * CLK_DIV && (cyc - last_fall) < 64)
        period_bad = period_bad + 1;
      fall_cnt  = fall_cnt + 1;
      last_fall = cyc;
    end
    mon_prev = ADCsclk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog sim time exceeded got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_start(input logic ch, input logic rg);
    start   = 1'b1;
    channel = ch;
    range   = rg;
    @(negedge clk);
    start   = 1'b0;
    channel = 1'b0;
    range   = 1'b0;
  endtask

  task automatic wait_sclk_fall(output bit ok);
    logic prev;
    prev = ADCsclk;
    ok   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (prev && !ADCsclk) begin
        ok = 1'b1;
        break;
      end
      prev = ADCsclk;
    end
  endtask

  // ADC model: RDY low after rdy_delay cycles, then next bit after each falling SCLK.
  task automatic adc_drive(input logic [23:0] word, input int rdy_delay, input int nbits);
    bit ok;
    tick(rdy_delay);
    ADCdin = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      wait_sclk_fall(ok);
      if (!ok) begin
        check("sclk_fall_wait", 32'd0, 32'd1);
        return;
      end
      ADCdin = word[23-i];
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (data_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [23:0] word, input logic ch, input logic rg, input string tag);
    bit          ok;
    int          fall_base;
    int          bad_base;
    logic [23:0] exp_word;
    exp_q.push_back(word);
    issue_start(ch, rg);
    check({tag, "_cs_low"}, ADCcs, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_sel_latch"}, ADCsel, ch);
    check({tag, "_rng_latch"}, ADCrng, rg);
    fall_base = fall_cnt;
    bad_base  = period_bad;
    adc_drive(word, RDY_DELAY, 24);
    wait_valid(ok);
    check({tag, "_valid"}, ok, 1'b1);
    exp_word = exp_q.pop_front();
    check({tag, "_data"}, data, exp_word);
    check({tag, "_cs_high_at_valid"}, ADCcs, 1'b1);
    check({tag, "_sclk_falls"}, fall_cnt - fall_base, 24);
    check({tag, "_sclk_period"}, period_bad - bad_base, 0);
    check({tag, "_mode"}, ADCmode, 1'b1);
    ADCdin = 1'b1;
  endtask

  task automatic ack_and_check(input string tag, input logic [23:0] exp_word);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check({tag, "_valid_drop"}, data_valid, 1'b0);
    check({tag, "_busy_drop"}, busy, 1'b0);
    check({tag, "_data_hold"}, data, exp_word);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int low_cnt;
    int pulses;
    int t_wait;
    int t_pulse;
    bit seen;

    // Reset state
    tick(3);
    check("rst_cs", ADCcs, 1'b1);
    check("rst_sclk", ADCsclk, 1'b1);
    check("rst_mode", ADCmode, 1'b1);
    check("rst_rng", ADCrng, 1'b0);
    check("rst_sel", ADCsel, 1'b0);
    check("rst_data", data, 24'h0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b1;
    tick(2);

    // ack while idle is ignored
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("idle_ack_state", dbg_state, IDLE);
    check("idle_ack_valid", data_valid, 1'b0);

    // Basic read + handshake hold with a start during DONE
    do_read(24'hA5C3F0, 1'b0, 1'b0, "basic");
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin
        start = 1'b1; channel = 1'b1; range = 1'b1;
      end else begin
        start = 1'b0; channel = 1'b0; range = 1'b0;
      end
      @(negedge clk);
      if (!data_valid) low_cnt++;
    end
    check("hs_valid_held", low_cnt, 0);
    check("hs_start_ignored_state", dbg_state, DONE);
    check("hs_start_ignored_sel", ADCsel, 1'b0);
    check("hs_start_ignored_rng", ADCrng, 1'b0);
    check("hs_start_ignored_cs", ADCcs, 1'b1);
    ack_and_check("basic", 24'hA5C3F0);

    // Config latch: channel=1, range=1
    tick(3);
    do_read(24'h123456, 1'b1, 1'b1, "cfg");
    ack_and_check("cfg", 24'h123456);
    tick(5);
    check("cfg_sel_persist", ADCsel, 1'b1);
    check("cfg_rng_persist", ADCrng, 1'b1);
    check("cfg_mode", ADCmode, 1'b1);

    // Back-to-back
    do_read(24'h800000, 1'b0, 1'b1, "b2b0");
    ack_and_check("b2b0", 24'h800000);
    do_read(24'h7FFFFF, 1'b1, 1'b0, "b2b1");
    ack_and_check("b2b1", 24'h7FFFFF);

    // Reset mid-shift after bit 10 of an all-ones word
    tick(3);
    issue_start(1'b0, 1'b0);
    adc_drive(24'hFFFFFF, RDY_DELAY, 11);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_cs", ADCcs, 1'b1);
    check("rstmid_sclk", ADCsclk, 1'b1);
    check("rstmid_data", data, 24'h0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_valid", data_valid, 1'b0);
    check("rstmid_sel", ADCsel, 1'b0);
    ADCdin = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    check("rstmid_state", dbg_state, IDLE);
    do_read(24'h000001, 1'b0, 1'b0, "after_rst");
    ack_and_check("after_rst", 24'h000001);

    // RDY never arrives
    tick(3);
    ADCdin = 1'b1;
    issue_start(1'b0, 1'b0);
`ifdef AD7782_TIMEOUT_EN
    seen = 1'b0;
    t_wait = 0;
    for (int i = 0; i < 100; i++) begin
      if (dbg_state == WAIT_RDY) begin
        seen = 1'b1;
        t_wait = cyc;
        break;
      end
      @(negedge clk);
    end
    check("tmo_wait_rdy_seen", seen, 1'b1);
    pulses  = 0;
    t_pulse = 0;
    for (int i = 0; i < TIMEOUT_CYCLES + 300; i++) begin
      @(negedge clk);
      if (timeout) begin
        pulses++;
        if (pulses == 1) begin
          t_pulse = cyc;
          check("tmo_cs_high", ADCcs, 1'b1);
        end
      end
    end
    check("tmo_pulses", pulses, 1);
    check("tmo_delay_ok", (t_pulse - t_wait >= TIMEOUT_CYCLES - 2) &&
                          (t_pulse - t_wait <= TIMEOUT_CYCLES + 2), 1'b1);
    check("tmo_valid", data_valid, 1'b0);
    check("tmo_data", data, 24'h000001);
    check("tmo_state", dbg_state, IDLE);
    check("tmo_busy", busy, 1'b0);
`else
    pulses  = 0;
    low_cnt = 0;
    for (int i = 0; i < TIMEOUT_CYCLES + 300; i++) begin
      @(negedge clk);
      if (timeout) pulses++;
      if (!busy) low_cnt++;
    end
    check("notmo_pulses", pulses, 0);
    check("notmo_busy_held", low_cnt, 0);
    check("notmo_state", dbg_state, WAIT_RDY);
    check("notmo_cs_low", ADCcs, 1'b0);
    check("notmo_valid", data_valid, 1'b0);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    check("notmo_recover_state", dbg_state, IDLE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
